// File: rtl/ram_rd_pkg.sv
// Shared types for the RAM B-port read controller: FSM states and burst modes.
package ram_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_CONT    = 1'b1;

endpackage

// File: rtl/ram_rd_ctrl_sync_fifo.sv
// Small first-word-fall-through FIFO used as the read controller's output buffer.
// The head word is visible combinationally; it reads as 0 while the FIFO is empty.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 3,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              do_push;
    logic              do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CNT_W'(DEPTH));
    assign count    = count_reg;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem_reg[rd_ptr_reg];

    // Storage write; no reset needed since empty masks stale contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/ram_rd_ctrl.sv
// Read controller for the RAM B port: issues bursts of len+1 reads (one-shot or
// continuous), tracks reads in flight through the RAM latency, and returns data
// in order on a valid/ready stream. Reads are only issued when the output buffer
// is guaranteed space (buffered + in-flight < FIFO_DEPTH), so nothing is dropped.
module ram_rd_ctrl #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 6,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = RD_LAT + 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len,
    input  logic              stop,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    import ram_rd_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    state_t            state_reg;
    logic              mode_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [ADDR_W-1:0] len_reg;
    logic [ADDR_W-1:0] addr_reg;   // next address to issue
    logic [ADDR_W-1:0] last_reg;   // most recently issued address
    logic [ADDR_W-1:0] cnt_reg;    // words issued so far in this pass
    logic [CNT_W-1:0]  in_flight_reg;
    logic [RD_LAT-1:0] vpipe_reg;
    logic              done_reg;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic              credit_ok;
    logic              issue;
    logic              last_issue;
    logic              push;
    logic              pop;

    assign credit_ok  = ({1'b0, fifo_count} + {1'b0, in_flight_reg}) < (CNT_W + 1)'(FIFO_DEPTH);
    assign issue      = (state_reg == READ) && credit_ok;
    assign last_issue = (cnt_reg == len_reg);
    assign push       = vpipe_reg[RD_LAT-1];
    assign pop        = out_valid && out_ready;

    assign ram_rd_en   = issue;
    assign ram_rd_addr = (state_reg != READ) ? '0 : (issue ? addr_reg : last_reg);
    assign out_valid   = !fifo_empty;
    assign busy        = (state_reg != IDLE);
    assign done        = done_reg;

    // Burst FSM with address/issue counters and the one-cycle done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            mode_reg  <= MODE_ONESHOT;
            base_reg  <= '0;
            len_reg   <= '0;
            addr_reg  <= '0;
            last_reg  <= '0;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= READ;
                        mode_reg  <= mode;
                        base_reg  <= base_addr;
                        len_reg   <= len;
                        addr_reg  <= base_addr;
                        cnt_reg   <= '0;
                    end
                end
                READ: begin
                    if (issue) begin
                        last_reg <= addr_reg;
                        if (last_issue) begin
                            cnt_reg  <= '0;
                            addr_reg <= base_reg;
                            if (mode_reg != MODE_CONT) begin
                                state_reg <= DRAIN;
                            end
                        end else begin
                            cnt_reg  <= cnt_reg + 1'b1;
                            addr_reg <= addr_reg + 1'b1;
                        end
                    end
                    if (stop) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((in_flight_reg == '0) && fifo_empty) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Valid shift register mirroring the RAM read latency.
    generate
        if (RD_LAT == 1) begin : g_pipe1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) vpipe_reg <= '0;
                else        vpipe_reg <= issue;
            end
        end else begin : g_pipen
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) vpipe_reg <= '0;
                else        vpipe_reg <= {vpipe_reg[RD_LAT-2:0], issue};
            end
        end
    endgenerate

    // Count of reads issued whose data has not yet landed in the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight_reg <= '0;
        end else begin
            case ({issue, push})
                2'b10:   in_flight_reg <= in_flight_reg + 1'b1;
                2'b01:   in_flight_reg <= in_flight_reg - 1'b1;
                default: in_flight_reg <= in_flight_reg;
            endcase
        end
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (ram_rd_data),
        .pop       (pop),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // The credit check must make a push into a full buffer impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full && !pop));

endmodule
